rob_dur_mon: RTL and testbench
==============================

# rob_dur_mon

Multi-slot reorder-buffer residency monitor: the parametrised successor to the single-entry duration probe. It tracks up to NUM_SLOTS sampled dispatched instructions at once and timestamps each one from dispatch to retire. Per latency class (slow = 0, fast = 1) it keeps the last, accumulated, count and maximum duration. It sits beside the active list and observes dispatch and retire index buses without back-pressuring them.

## Interface

Parameters:
- IDX_W, 8, active-list index width
- TS_W, 10, timestamp/duration width (timestamp already LSB-dropped upstream)
- NUM_SLOTS, 4, concurrent monitor slots (1..16)
- ACC_W, 24, per-class duration accumulator width
- CNT_W, 16, per-class sample counter and drop counter width

Ports:
- clk, in, 1, single clock; all state on rising edge
- reset_n, in, 1, reset, asynchronous, active-low
- timestamp, in, TS_W, free-running time base, wraps modulo 2^TS_W
- dp_valid, in, 1, an instruction dispatches this cycle
- dp_sample, in, 1, qualifies dp_valid: monitor this instruction
- dp_idx, in, IDX_W, active-list index of dispatching instruction
- dp_class, in, 1, latency class of the instruction (1 = fast)
- rt_valid, in, 1, an instruction retires this cycle
- rt_idx, in, IDX_W, active-list index of retiring instruction
- flush, in, 1, pipeline squash: abandon all in-flight samples
- clear_stats, in, 1, zero all statistics outputs
- dur_last, out, 2*TS_W, last duration per class, [TS_W-1:0] = class 0
- dur_sum, out, 2*ACC_W, saturating duration sum per class
- dur_cnt, out, 2*CNT_W, saturating completed-sample count per class
- dur_max, out, 2*TS_W, maximum duration per class
- drop_cnt, out, CNT_W, saturating count of samples refused because no slot was free
- slots_busy, out, NUM_SLOTS, per-slot active flag

## Operation

- Each slot holds: active, idx, start timestamp, class.
- **Allocation**
  - When dp_valid && dp_sample, the lowest-numbered slot inactive at the start of the cycle is loaded with dp_idx, timestamp and dp_class, and is set active.
  - If no slot is free, drop_cnt increments, saturating at 2^CNT_W-1.
- **Completion**
  - When rt_valid, every active slot with idx == rt_idx is freed.
  - The lowest-numbered matching slot alone is reported. Its duration is timestamp - start, modulo 2^TS_W.
  - Stats for that slot's class update as follows:
    - dur_last ← duration
    - dur_sum ← sum + duration, saturating at 2^ACC_W-1
    - dur_cnt ← cnt + 1, saturating
    - dur_max ← max(dur_max, duration)
- **Same-cycle events**
  - A slot freed by completion is not reusable for allocation in the same cycle.
  - A slot allocated this cycle is not matched by this cycle's rt_idx, even if dp_idx == rt_idx.
- **flush** clears every active flag.
  - It suppresses allocation and completion in that cycle.
  - Statistics and drop_cnt are preserved.
- **clear_stats**
  - Zeros dur_last, dur_sum, dur_cnt, dur_max and drop_cnt.
  - Slots are untouched.
  - If clear_stats coincides with a completion or a drop, the clear wins and that event is discarded.
- **Durations at or beyond one timestamp wrap** alias silently (modulo arithmetic). This is accepted.

## Timing

- Reset (reset_n low, asynchronous) drives every output and every slot field to 0 immediately.
- Allocation is visible on slots_busy one cycle after the dp_valid cycle.
- Completion: stats and slots_busy reflect the retire one cycle after the rt_valid cycle.
- A slot allocated in cycle N can complete at the earliest in cycle N+1, giving a minimum duration equal to the timestamp delta over one cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- reset_n asserted mid-flight drops all samples with no stat update. The first allocation is possible in the first clock edge after deassertion.

## Configuration

- Macro: ROB_DUR_MAX_EN.
- **Defined:** dur_max is tracked as described.
- **Undefined:**
  - The max comparators and registers are not built.
  - dur_max is tied to 0.
  - All other behaviour is identical.

## Test plan

- **Single sample:** dispatch idx 5 class 0 at ts 100, retire idx 5 at ts 130.
  - Next cycle: dur_last[class0]=30, dur_sum=30, dur_cnt=1, dur_max=30.
  - Class 1 fields remain 0.
- **Slot exhaustion (NUM_SLOTS=4):** sample idx 1..5 on consecutive cycles with no retire.
  - slots_busy=4'b1111 and drop_cnt=1.
  - Retiring idx 3 then frees slot 2 only.
- **Wrap-around:** start ts 1020, retire at ts 4 (TS_W=10) → duration 8.
- **Simultaneous events:** in one cycle, dispatch-sample idx 7 while retiring active idx 7.
  - The old slot completes.
  - The new slot (lowest free at cycle start) allocates and stays active.
  - A later retire of idx 7 completes the new slot.
- **flush and clear:** with 3 slots active, assert flush.
  - slots_busy=0 next cycle; stats unchanged.
  - Then clear_stats coincident with a retire: all stats 0, dur_cnt stays 0.
- **Reset mid-flight and macro off:**
  - Assert reset_n low with 2 slots active: all outputs 0 asynchronously.
  - With ROB_DUR_MAX_EN undefined, dur_max reads 0 after any completion.

Source files
------------

// File: rtl/rob_dur_mon.sv
// Reorder-buffer residency monitor: times up to NUM_SLOTS sampled instructions from dispatch to retire
// and keeps per-class last/sum/count/max duration statistics. Optional max tracking: ROB_DUR_MAX_EN.
module rob_dur_mon #(
  parameter int IDX_W     = 8,
  parameter int TS_W      = 10,
  parameter int NUM_SLOTS = 4,
  parameter int ACC_W     = 24,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [TS_W-1:0]      timestamp,
  input  logic                 dp_valid,
  input  logic                 dp_sample,
  input  logic [IDX_W-1:0]     dp_idx,
  input  logic                 dp_class,
  input  logic                 rt_valid,
  input  logic [IDX_W-1:0]     rt_idx,
  input  logic                 flush,
  input  logic                 clear_stats,
  output logic [2*TS_W-1:0]    dur_last,
  output logic [2*ACC_W-1:0]   dur_sum,
  output logic [2*CNT_W-1:0]   dur_cnt,
  output logic [2*TS_W-1:0]    dur_max,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [NUM_SLOTS-1:0] slots_busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_SLOTS-1:0] slot_active;
  logic [NUM_SLOTS-1:0] slot_class;
  logic [IDX_W-1:0]     slot_idx   [NUM_SLOTS];
  logic [TS_W-1:0]      slot_start [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] match;
  logic [NUM_SLOTS-1:0] alloc_oh;
  logic                 any_free;
  logic                 rpt_valid;
  logic                 rpt_class;
  logic [TS_W-1:0]      rpt_start;
  logic [TS_W-1:0]      rpt_dur;
  logic                 alloc_go;
  logic                 drop_evt;

  // Free slots are judged on start-of-cycle state, so a slot retiring now is never reused this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    match     = '0;
    alloc_oh  = '0;
    any_free  = 1'b0;
    rpt_valid = 1'b0;
    rpt_class = 1'b0;
    rpt_start = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      match[i] = rt_valid && !flush && slot_active[i] && (slot_idx[i] == rt_idx);
      if (match[i] && !rpt_valid) begin
        rpt_valid = 1'b1;
        rpt_class = slot_class[i];
        rpt_start = slot_start[i];
      end
      if (!slot_active[i] && !any_free) begin
        alloc_oh[i] = 1'b1;
        any_free    = 1'b1;
      end
    end
    rpt_dur  = timestamp - rpt_start;
    alloc_go = dp_valid && dp_sample && !flush && any_free;
    drop_evt = dp_valid && dp_sample && !flush && !any_free;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the slot arrays are reset too, so every slot field reads 0 after reset.
    if (!reset_n) begin
      slot_active <= '0;
      slot_class  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_idx[i]   <= '0;
        slot_start[i] <= '0;
      end
    end else if (flush) begin
      slot_active <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        // NOTE: non-blocking updates keep every slot reading start-of-cycle state.
        if (match[i]) slot_active[i] <= 1'b0;
        if (alloc_go && alloc_oh[i]) begin
          slot_active[i] <= 1'b1;
          slot_idx[i]    <= dp_idx;
          slot_start[i]  <= timestamp;
          slot_class[i]  <= dp_class;
        end
      end
    end
  end

  logic [TS_W-1:0]  last_q [2];
  logic [ACC_W-1:0] sum_q  [2];
  logic [CNT_W-1:0] cnt_q  [2];
  logic [CNT_W-1:0] drop_q;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_sat;
  logic [CNT_W-1:0] cnt_sat;

  always_comb begin
    sum_ext = {1'b0, sum_q[rpt_class]} + (ACC_W + 1)'(rpt_dur);
    sum_sat = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    cnt_sat = (cnt_q[rpt_class] == '1) ? cnt_q[rpt_class] : cnt_q[rpt_class] + CNT_ONE;
  end

  // clear_stats outranks a coincident completion or drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= '0;
      for (int c = 0; c < 2; c++) begin
        last_q[c] <= '0;
        sum_q[c]  <= '0;
        cnt_q[c]  <= '0;
      end
    end else if (clear_stats) begin
      drop_q <= '0;
      for (int c = 0; c < 2; c++) begin
        last_q[c] <= '0;
        sum_q[c]  <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      if (rpt_valid) begin
        last_q[rpt_class] <= rpt_dur;
        sum_q[rpt_class]  <= sum_sat;
        cnt_q[rpt_class]  <= cnt_sat;
      end
      if (drop_evt && drop_q != '1) drop_q <= drop_q + CNT_ONE;
    end
  end

`ifdef ROB_DUR_MAX_EN
  logic [TS_W-1:0] max_q [2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_q[0] <= '0;
      max_q[1] <= '0;
    end else if (clear_stats) begin
      max_q[0] <= '0;
      max_q[1] <= '0;
    end else if (rpt_valid && rpt_dur > max_q[rpt_class]) begin
      max_q[rpt_class] <= rpt_dur;
    end
  end

  assign dur_max = {max_q[1], max_q[0]};
`else
  assign dur_max = '0;
`endif

  assign dur_last   = {last_q[1], last_q[0]};
  assign dur_sum    = {sum_q[1], sum_q[0]};
  assign dur_cnt    = {cnt_q[1], cnt_q[0]};
  assign drop_cnt   = drop_q;
  assign slots_busy = slot_active;

endmodule

// File: tb/tb_rob_dur_mon.sv
// Self-checking bench for rob_dur_mon: directed scenarios then random traffic against a slot-list model.
module tb_rob_dur_mon;
  localparam int IDX_W = 8, TS_W = 10, NS = 4, ACC_W = 24, CNT_W = 16;
  localparam longint SUM_MAX = (64'd1 << ACC_W) - 1;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  logic              clk, reset_n;
  logic [TS_W-1:0]   timestamp;
  logic              dp_valid, dp_sample, dp_class, rt_valid, flush, clear_stats;
  logic [IDX_W-1:0]  dp_idx, rt_idx;
  logic [2*TS_W-1:0] dur_last, dur_max;
  logic [2*ACC_W-1:0] dur_sum;
  logic [2*CNT_W-1:0] dur_cnt;
  logic [CNT_W-1:0]  drop_cnt;
  logic [NS-1:0]     slots_busy;

  rob_dur_mon #(.IDX_W(IDX_W), .TS_W(TS_W), .NUM_SLOTS(NS), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .timestamp(timestamp),
    .dp_valid(dp_valid), .dp_sample(dp_sample), .dp_idx(dp_idx), .dp_class(dp_class),
    .rt_valid(rt_valid), .rt_idx(rt_idx), .flush(flush), .clear_stats(clear_stats),
    .dur_last(dur_last), .dur_sum(dur_sum), .dur_cnt(dur_cnt), .dur_max(dur_max),
    .drop_cnt(drop_cnt), .slots_busy(slots_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a list of slots plus per-class statistics kept as plain integers.
  bit          m_active [NS];
  int          m_idx    [NS];
  int          m_start  [NS];
  bit          m_cls    [NS];
  longint      m_last [2], m_sum [2], m_cnt [2], m_max [2];
  longint      m_drop;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_active[i] = 0; m_idx[i] = 0; m_start[i] = 0; m_cls[i] = 0;
    end
    for (int c = 0; c < 2; c++) begin
      m_last[c] = 0; m_sum[c] = 0; m_cnt[c] = 0; m_max[c] = 0;
    end
    m_drop = 0;
  endtask

  task automatic model_tick();
    int free_i = -1;
    int rep_i = -1;
    int d = 0;
    bit drop = 0;
    for (int i = 0; i < NS; i++)
      if (!m_active[i] && free_i < 0) free_i = i;
    if (flush) begin
      for (int i = 0; i < NS; i++) m_active[i] = 0;
    end else begin
      if (rt_valid)
        for (int i = 0; i < NS; i++)
          if (m_active[i] && m_idx[i] == int'(rt_idx)) begin
            if (rep_i < 0) rep_i = i;
            m_active[i] = 0;
          end
      if (rep_i >= 0) d = (int'(timestamp) - m_start[rep_i] + (1 << TS_W)) % (1 << TS_W);
      if (dp_valid && dp_sample) begin
        if (free_i >= 0) begin
          m_active[free_i] = 1;
          m_idx[free_i]    = int'(dp_idx);
          m_start[free_i]  = int'(timestamp);
          m_cls[free_i]    = dp_class;
        end else drop = 1;
      end
    end
    if (clear_stats) begin
      for (int c = 0; c < 2; c++) begin
        m_last[c] = 0; m_sum[c] = 0; m_cnt[c] = 0; m_max[c] = 0;
      end
      m_drop = 0;
    end else begin
      if (rep_i >= 0) begin
        int c = int'(m_cls[rep_i]);
        m_last[c] = d;
        m_sum[c]  = (m_sum[c] + d > SUM_MAX) ? SUM_MAX : m_sum[c] + d;
        m_cnt[c]  = (m_cnt[c] < CNT_MAX) ? m_cnt[c] + 1 : CNT_MAX;
        if (d > m_max[c]) m_max[c] = d;
      end
      if (drop && m_drop < CNT_MAX) m_drop++;
    end
  endtask

  task automatic check_all();
    logic [NS-1:0] busy;
    logic [2*TS_W-1:0] exp_max;
    for (int i = 0; i < NS; i++) busy[i] = m_active[i];
`ifdef ROB_DUR_MAX_EN
    exp_max = {TS_W'(m_max[1]), TS_W'(m_max[0])};
`else
    exp_max = '0;
`endif
    check("slots_busy", 64'(slots_busy), 64'(busy));
    check("dur_last", 64'(dur_last), 64'({TS_W'(m_last[1]), TS_W'(m_last[0])}));
    check("dur_sum", 64'(dur_sum), 64'({ACC_W'(m_sum[1]), ACC_W'(m_sum[0])}));
    check("dur_cnt", 64'(dur_cnt), 64'({CNT_W'(m_cnt[1]), CNT_W'(m_cnt[0])}));
    check("dur_max", 64'(dur_max), 64'(exp_max));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic step(input bit dv, input bit ds, input int di, input bit dc,
                      input bit rv, input int ri, input bit fl, input bit cs, input int t);
    dp_valid = dv; dp_sample = ds; dp_idx = IDX_W'(di); dp_class = dc;
    rt_valid = rv; rt_idx = IDX_W'(ri); flush = fl; clear_stats = cs;
    timestamp = TS_W'(t);
    model_tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 64'(slots_busy), 64'd0);
    check({tag, "_last"}, 64'(dur_last), 64'd0);
    check({tag, "_sum"}, 64'(dur_sum), 64'd0);
    check({tag, "_cnt"}, 64'(dur_cnt), 64'd0);
    check({tag, "_max"}, 64'(dur_max), 64'd0);
    check({tag, "_drop"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    dp_valid = 0; dp_sample = 0; dp_idx = '0; dp_class = 0;
    rt_valid = 0; rt_idx = '0; flush = 0; clear_stats = 0; timestamp = '0;
    model_reset();
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Single sample: idx 5 class 0, ts 100 -> 130.
    step(1, 1, 5, 0, 0, 0, 0, 0, 100);
    check("single_alloc_busy", 64'(slots_busy), 64'b0001);
    step(0, 0, 0, 0, 1, 5, 0, 0, 130);
    check("single_last0", 64'(dur_last[TS_W-1:0]), 64'd30);
    check("single_cnt0", 64'(dur_cnt[CNT_W-1:0]), 64'd1);
    check("single_class1_last", 64'(dur_last[2*TS_W-1:TS_W]), 64'd0);

    // Slot exhaustion: idx 1..5 back to back; fifth is dropped.
    for (int k = 1; k <= 5; k++) step(1, 1, k, 0, 0, 0, 0, 0, 200 + k);
    check("exhaust_busy", 64'(slots_busy), 64'b1111);
    check("exhaust_drop", 64'(drop_cnt), 64'd1);
    step(0, 0, 0, 0, 1, 3, 0, 0, 210);
    check("exhaust_free_slot2", 64'(slots_busy), 64'b1011);

    // Flush with three slots active keeps statistics.
    step(0, 0, 0, 0, 0, 0, 1, 0, 211);
    check("flush_busy", 64'(slots_busy), 64'd0);
    check("flush_cnt_kept", 64'(dur_cnt), 64'd2);

    // clear_stats wins over a coincident retire.
    step(1, 1, 9, 0, 0, 0, 0, 0, 220);
    step(0, 0, 0, 0, 1, 9, 0, 1, 240);
    check("clear_cnt", 64'(dur_cnt), 64'd0);
    check("clear_drop", 64'(drop_cnt), 64'd0);

    // Timestamp wrap: 1020 -> 4 gives 8.
    step(1, 1, 20, 1, 0, 0, 0, 0, 1020);
    step(0, 0, 0, 0, 1, 20, 0, 0, 4);
    check("wrap_last1", 64'(dur_last[2*TS_W-1:TS_W]), 64'd8);

    // Dispatch and retire of the same idx in one cycle.
    step(1, 1, 7, 0, 0, 0, 0, 0, 300);
    step(1, 1, 7, 1, 1, 7, 0, 0, 310);
    check("simul_busy", 64'(slots_busy), 64'b0010);
    check("simul_last0", 64'(dur_last[TS_W-1:0]), 64'd10);
    step(0, 0, 0, 0, 1, 7, 0, 0, 325);
    check("simul_second_last1", 64'(dur_last[2*TS_W-1:TS_W]), 64'd15);
    check("simul_second_busy", 64'(slots_busy), 64'd0);

    // Asynchronous reset with two slots in flight.
    step(1, 1, 30, 0, 0, 0, 0, 0, 400);
    step(1, 1, 31, 1, 0, 0, 0, 0, 401);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs_zero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 1, 40, 0, 0, 0, 0, 0, 500);
    check("post_reset_alloc", 64'(slots_busy), 64'b0001);

    // Random traffic with a small idx range so retires hit often.
    begin
      int t = 600;
      for (int n = 0; n < 400; n++) begin
        t = (t + int'($urandom_range(0, 40))) % (1 << TS_W);
        step($urandom_range(0, 99) < 60, $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), $urandom_range(0, 99) < 50, int'($urandom_range(0, 7)),
             $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3, t);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
